// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: push handshake, RAM write port,
// Gray pointer exchange with the read domain and status flags.
interface afifo_wr_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [ADDR_WIDTH:0]   rd_gray_ptr;
    logic [ADDR_WIDTH:0]   wr_gray_ptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;
    logic                  ovf_clr;

    modport master (
        output wr_valid, wr_data, rd_gray_ptr, ovf_clr,
        input  wr_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
               wr_gray_ptr, full, almost_full, wr_count, overflow
    );

    modport slave (
        input  wr_valid, wr_data, rd_gray_ptr, ovf_clr,
        output wr_ready, ram_wr_en, ram_wr_addr, ram_wr_data,
               wr_gray_ptr, full, almost_full, wr_count, overflow
    );
endinterface

// File: rtl/afifo_wr_ctrl.sv
// Async FIFO write-side controller: accepts pushes, drives the RAM write port,
// publishes a Gray write pointer and derives full/occupancy from the synced read pointer.
module afifo_wr_ctrl #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = DEPTH - 4
) (
    input  logic               wr_clk,
    input  logic               rst_n,
    afifo_wr_ctrl_if.slave     bus
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    // Full when the write Gray pointer equals the read one with its two MSBs inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("afifo_wr_ctrl: DEPTH must be a power of 2 and >= 2");
        end
        if (ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_aw
            $error("afifo_wr_ctrl: ADDR_WIDTH must equal clog2(DEPTH)");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("afifo_wr_ctrl: SYNC_STAGES must be >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("afifo_wr_ctrl: AF_THRESH must be in 1..DEPTH");
        end
    endgenerate

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int i = 0; i < int'(PW); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic                  push_c;
    logic [PW-1:0]         rq_gray_c;
    logic [PW-1:0]         rq_bin_c;
    logic [DATA_WIDTH-1:0] data_c;

    // Next-state: pointer advance, read-pointer synchronizer and status flags.
    always_comb begin
        push_c    = bus.wr_valid & ~full_q;
        wbin_d    = wbin_q + PW'(push_c);
        wgray_d   = wbin_d ^ (wbin_d >> 1);
        sync_d[0] = bus.rd_gray_ptr;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        rq_gray_c = sync_q[SYNC_STAGES-1];
        rq_bin_c  = gray2bin(rq_gray_c);
        count_d   = wbin_d - rq_bin_c;
        full_d    = (wgray_d == (rq_gray_c ^ FULL_MASK));
        af_d      = (count_d >= PW'(AF_THRESH));
        // A refused push sets overflow even when a clear arrives on the same edge.
        ovf_d     = (bus.wr_valid & full_q) | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
            full_q  <= full_d;
            af_q    <= af_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_c          = bus.wr_data;
    assign bus.wr_ready    = ~full_q;
    assign bus.ram_wr_en   = push_c;
    assign bus.ram_wr_addr = wbin_q[ADDR_WIDTH-1:0];
    assign bus.ram_wr_data = data_c;
    assign bus.wr_gray_ptr = wgray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wr_count    = count_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Bench for afifo_wr_ctrl: directed scenarios plus a random phase, checked
// against an occupancy model built from unbounded write/read counters.
module tb_afifo_wr_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned AFT   = 12;

    logic wr_clk;
    logic rst_n;

    afifo_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    afifo_wr_ctrl #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .SYNC_STAGES(SYNC), .AF_THRESH(AFT)
    ) dut (
        .wr_clk (wr_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: total writes accepted, reader position driven, and the read
    // positions still in flight through the synchronizer.
    int m_wr;
    int m_rd_drv;
    int hist[$];
    bit m_full, m_af, m_ovf;
    int m_count;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0;
        hist = {};
        repeat (SYNC) hist.push_back(0);
        m_full  = 1'b0;
        m_af    = 1'b0;
        m_ovf   = 1'b0;
        m_count = 0;
    endtask

    task automatic check_regs(input string ph);
        chk({ph, ".wr_gray_ptr"}, 64'(bus.wr_gray_ptr), 64'(gray(m_wr)));
        chk({ph, ".full"},        64'(bus.full),        64'(m_full));
        chk({ph, ".almost_full"}, 64'(bus.almost_full), 64'(m_af));
        chk({ph, ".wr_count"},    64'(bus.wr_count),    64'(m_count));
        chk({ph, ".overflow"},    64'(bus.overflow),    64'(m_ovf));
        chk({ph, ".wr_ready"},    64'(bus.wr_ready),    64'(!m_full));
    endtask

    // One cycle: drive at posedge+1, check write port, clock, update model, check flags.
    task automatic step(input bit v, input bit clr);
        logic [DW-1:0] d;
        bit            push;
        int            rq;
        int            occ;
        d = $urandom;
        bus.wr_valid    = v;
        bus.wr_data     = d;
        bus.ovf_clr     = clr;
        bus.rd_gray_ptr = gray(m_rd_drv);
        #1;
        push = v && !m_full;
        chk("ram_wr_en",   64'(bus.ram_wr_en),   64'(push));
        chk("ram_wr_addr", 64'(bus.ram_wr_addr), 64'(m_wr % int'(DEPTH)));
        chk("ram_wr_data", 64'(bus.ram_wr_data), 64'(d));
        @(posedge wr_clk);
        rq = hist.pop_front();
        hist.push_back(m_rd_drv);
        m_ovf = (v && m_full) || (m_ovf && !clr);
        if (push) m_wr++;
        occ     = m_wr - rq;
        m_count = occ;
        m_full  = (occ == int'(DEPTH));
        m_af    = (occ >= int'(AFT));
        #1;
        check_regs("step");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge wr_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b1;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.ovf_clr     = 1'b0;
        bus.rd_gray_ptr = '0;
        m_rd_drv        = 0;

        // Asynchronous reset with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        chk("async_rst.gray_zero", 64'(bus.wr_gray_ptr), 64'd0);
        repeat (2) @(posedge wr_clk);
        #1;
        rst_n = 1'b1;

        // Fill from empty.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0);
            if (i == 11) chk("fill.af_at_12", 64'(bus.almost_full), 64'd1);
            if (i == 15) begin
                chk("fill.full_at_16",  64'(bus.full),        64'd1);
                chk("fill.count_16",    64'(bus.wr_count),    64'd16);
                chk("fill.gray_11000",  64'(bus.wr_gray_ptr), 64'b11000);
            end
        end

        // Overflow set, set-wins-over-clear, then clear alone.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("ovf.set", 64'(bus.overflow), 64'd1);
        chk("ovf.ptr_held", 64'(bus.wr_gray_ptr), 64'b11000);
        step(1'b1, 1'b1);
        chk("ovf.set_wins", 64'(bus.overflow), 64'd1);
        step(1'b0, 1'b1);
        chk("ovf.cleared", 64'(bus.overflow), 64'd0);

        // Reader advances to 4: seen after SYNC+1 edges.
        m_rd_drv = 4;
        step(1'b0, 1'b0);
        chk("drain.full_e1", 64'(bus.full), 64'd1);
        step(1'b0, 1'b0);
        chk("drain.full_e2", 64'(bus.full), 64'd1);
        step(1'b0, 1'b0);
        chk("drain.full_e3",  64'(bus.full),        64'd0);
        chk("drain.count_12", 64'(bus.wr_count),    64'd12);
        chk("drain.af",       64'(bus.almost_full), 64'd1);
        repeat (4) step(1'b1, 1'b0);
        chk("refill.full", 64'(bus.full), 64'd1);

        // Wrap with the reader trailing three entries behind.
        m_rd_drv = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            m_rd_drv = (m_wr >= 3) ? m_wr - 3 : 0;
            step(1'b1, 1'b0);
            chk("wrap.no_full", 64'(bus.full), 64'd0);
            chk("wrap.count_bound", 64'(bus.wr_count <= 5'(3 + SYNC + 1)), 64'd1);
            if (m_wr == 31) chk("wrap.gray_31", 64'(bus.wr_gray_ptr), 64'b10000);
            if (m_wr == 32) chk("wrap.gray_0",  64'(bus.wr_gray_ptr), 64'b00000);
        end
        chk("wrap.total", 64'(m_wr), 64'd40);

        // Reset in the middle of a burst.
        m_rd_drv = 0;
        do_reset();
        repeat (7) step(1'b1, 1'b0);
        chk("burst.addr_7", 64'(bus.ram_wr_addr), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("mid_rst");
        chk("mid_rst.addr", 64'(bus.ram_wr_addr), 64'd0);
        @(posedge wr_clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk("post_rst.one_write", 64'(bus.wr_count), 64'd1);

        // Random traffic with a slow reader and occasional clears.
        m_rd_drv = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3) == 0 && m_rd_drv < m_wr) m_rd_drv++;
            step(($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
